// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg
//   Shared definitions for the fifo_reader block and its skid buffer:
//   the controller state encoding, the default data width and the width
//   of the optional statistics counters.
//   The statistics counters exist only when FIFO_RD_STATS_EN is defined.
package fifo_reader_pkg;

  // Controller states. FLUSH drains the fifo and discards whatever it returns.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 8;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf
//   Circular skid buffer between the fifo read port and the downstream
//   valid/ready stream. The head entry is always presented on head_data.
//   Ports:
//     clk, rst         clock, asynchronous active-low reset
//     clear            synchronous empty (wins over push and pop)
//     push, push_data  write one entry at the tail
//     pop              retire the head entry (caller guarantees count != 0)
//     head_data        current head entry
//     count            occupancy, 0..DEPTH
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full buffer only happens together with a pop, so the
  // slot being overwritten is the one the head is leaving.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
//   Consumer-side controller for the 8-bit fifo. Issues rd strobes while the
//   fifo reports data and the skid buffer has room for everything already
//   requested, captures fifo_data RD_LAT cycles later and re-presents the
//   bytes on a valid/ready stream.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     en                  enables issuing reads
//     flush               one-cycle pulse: empty the buffer, drain the fifo
//     fifo_ready          fifo non-empty flag
//     fifo_data           fifo data_out
//     fifo_rd             read strobe to the fifo
//     m_valid/m_data      downstream byte (head of the skid buffer)
//     m_ready             downstream accept
//     busy                state not IDLE or a read still in flight
//     rd_count            popped bytes, wrapping      (FIFO_RD_STATS_EN only)
//     stall_count         stalled cycles, saturating  (FIFO_RD_STATS_EN only)
//   Optional statistics are built only when FIFO_RD_STATS_EN is defined.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int BUF_DEPTH = 2,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          fifo_ready,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] stall_count
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int IW = $clog2(RD_LAT + 1);

  state_t        state;
  logic [RD_LAT-1:0] inflight;
  logic [IW-1:0] inflight_cnt;
  logic [CW-1:0] occ;
  logic          pop;
  logic          push;

  // Number of reads issued whose data has not yet arrived.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) inflight_cnt = inflight_cnt + IW'(inflight[i]);
  end

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  // Bytes returning while flushing are thrown away.
  assign push    = inflight[RD_LAT-1] && (state != FLUSH);
  assign busy    = (state != IDLE) || (inflight != '0);

  // A read is allowed only if every outstanding byte still has a slot. The
  // byte leaving on this edge frees its slot now, which is what lets a
  // two-entry buffer stream one byte per cycle at RD_LAT=1.
  always_comb begin
    fifo_rd = 1'b0;
    if (((state == RUN && en) || state == FLUSH) && fifo_ready)
      fifo_rd = (int'(occ) + int'(inflight_cnt) - int'(pop)) < BUF_DEPTH;
  end

  // Controller state and the in-flight shift register of issued reads.
  // flush overrides every other transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      inflight <= '0;
    end else begin
      inflight[0] <= fifo_rd;
      for (int i = 1; i < RD_LAT; i++) inflight[i] <= inflight[i-1];
      if (flush) begin
        state <= FLUSH;
      end else begin
        case (state)
          IDLE:    if (en) state <= RUN;
          RUN:     if (!en && inflight_cnt == '0) state <= IDLE;
          FLUSH:   if (!fifo_ready && inflight == '0 && occ == '0) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  fifo_reader_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (m_data),
    .count     (occ)
  );

`ifdef FIFO_RD_STATS_EN
  // rd_count wraps freely; stall_count sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count    <= '0;
      stall_count <= '0;
    end else if (flush) begin
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (pop) rd_count <= rd_count + 1'b1;
      if (m_valid && !m_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule
